alu_fun_dispatcher: RTL and testbench

Registered, parametrised successor to the ALU function decoder. It accepts an ALU function code through a valid/ready handshake and drives a held one-hot enable to the selected unit (Arithmetic, Logic, CMP, Shift, or more units when widened). It waits for that unit's completion, then reports the result with a one-cycle valid pulse. It sits between the ALU command source and the function units, serialising operations and tracking completed-operation count, with an optional watchdog.

---
 rtl/alu_fun_dispatcher.sv | 133 +++++++++++++
 tb/tb_alu_fun_dispatcher.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/alu_fun_dispatcher.sv
// Registered ALU function dispatcher: valid/ready accept, held one-hot unit enable, done-driven completion.
// Optional BUSY watchdog compiled in with `define DISPATCH_WATCHDOG_EN.
module alu_fun_dispatcher #(
    parameter int unsigned FUN_W       = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  In_Valid,
    input  logic [FUN_W-1:0]      ALU_FUN,
    output logic                  In_Ready,
    input  logic [(2**FUN_W)-1:0] Unit_Done,
    output logic [(2**FUN_W)-1:0] Unit_Enable,
    output logic [FUN_W-1:0]      Active_Fun,
    output logic                  Out_Valid,
    output logic [CNT_W-1:0]      Op_Count,
    output logic                  Timeout_Err
);

    localparam int unsigned N = 2 ** FUN_W;

    if (TIMEOUT_CYC < 1) begin : g_cfg_err
        $error("TIMEOUT_CYC must be >= 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [N-1:0]     en_q, en_d;
    logic [FUN_W-1:0] fun_q, fun_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_c;

    // Only the active unit's completion is ever observed.
    assign done_c = Unit_Done[fun_q];

`ifdef DISPATCH_WATCHDOG_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC + 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              tmo_q, tmo_d;
    logic              expire_c;

    assign expire_c = (wait_q == WAIT_W'(TIMEOUT_CYC - 1));
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            en_q        <= '0;
            fun_q       <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
`ifdef DISPATCH_WATCHDOG_EN
            wait_q      <= '0;
            tmo_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            en_q        <= en_d;
            fun_q       <= fun_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
`ifdef DISPATCH_WATCHDOG_EN
            wait_q      <= wait_d;
            tmo_q       <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        en_d        = en_q;
        fun_d       = fun_q;
        out_valid_d = 1'b0;
        cnt_d       = cnt_q;
`ifdef DISPATCH_WATCHDOG_EN
        wait_d      = wait_q;
        tmo_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (In_Valid) begin
                    fun_d   = ALU_FUN;
                    en_d    = N'(1) << ALU_FUN;
                    state_d = BUSY;
`ifdef DISPATCH_WATCHDOG_EN
                    wait_d  = '0;
`endif
                end
            end
            BUSY: begin
                // Done takes priority over a coincident watchdog expiry.
                if (done_c) begin
                    en_d        = '0;
                    out_valid_d = 1'b1;
                    cnt_d       = cnt_q + CNT_W'(1);
                    state_d     = IDLE;
`ifdef DISPATCH_WATCHDOG_EN
                end else if (expire_c) begin
                    en_d    = '0;
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
    end

    assign In_Ready    = in_ready_q;
    assign Unit_Enable = en_q;
    assign Active_Fun  = fun_q;
    assign Out_Valid   = out_valid_q;
    assign Op_Count    = cnt_q;
`ifdef DISPATCH_WATCHDOG_EN
    assign Timeout_Err = tmo_q;
`else
    assign Timeout_Err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_fun_dispatcher.sv
// Scoreboard bench for alu_fun_dispatcher: random ops with a transaction-level model; optional DISPATCH_WATCHDOG_EN.
module tb_alu_fun_dispatcher;

    localparam int FUN_W = 2;
    localparam int N     = 4;
    localparam int CNT_W = 2;
    localparam int TMO   = 4;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             In_Valid = 1'b0;
    logic [FUN_W-1:0] ALU_FUN = '0;
    logic             In_Ready;
    logic [N-1:0]     Unit_Done = '0;
    logic [N-1:0]     Unit_Enable;
    logic [FUN_W-1:0] Active_Fun;
    logic             Out_Valid;
    logic [CNT_W-1:0] Op_Count;
    logic             Timeout_Err;

    alu_fun_dispatcher #(.FUN_W(FUN_W), .CNT_W(CNT_W), .TIMEOUT_CYC(TMO)) dut (
        .CLK(CLK), .RST(RST), .In_Valid(In_Valid), .ALU_FUN(ALU_FUN), .In_Ready(In_Ready),
        .Unit_Done(Unit_Done), .Unit_Enable(Unit_Enable), .Active_Fun(Active_Fun),
        .Out_Valid(Out_Valid), .Op_Count(Op_Count), .Timeout_Err(Timeout_Err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit tmo;
        int fun;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   model_cnt = 0;
    bit   watchdog = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int onehot(input int f);
        return 1 << f;
    endfunction

    // Monitor: every completion/abort pulse must match the oldest expected event.
    always @(negedge CLK) begin
        if (RST && (Out_Valid || Timeout_Err)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_valid", int'(Out_Valid), e.tmo ? 0 : 1);
                chk("timeout_err", int'(Timeout_Err), e.tmo ? 1 : 0);
                chk("active_fun", int'(Active_Fun), e.fun);
                chk("op_count", int'(Op_Count), e.cnt);
                chk("enable_idle", int'(Unit_Enable), 0);
                chk("in_ready_evt", int'(In_Ready), 1);
            end
        end
    end

    // One command: done asserted in BUSY cycle d (1-based); watchdog aborts if d > TMO.
    task automatic do_op(input int fun, input int d, input bit gap);
        bit tmo;
        int busy;
        tmo  = watchdog && (d > TMO);
        busy = tmo ? TMO : d;
        @(negedge CLK);
        chk("in_ready_accept", int'(In_Ready), 1);
        In_Valid  = 1'b1;
        ALU_FUN   = FUN_W'(fun);
        Unit_Done = N'($urandom);
        if (!tmo) model_cnt = (model_cnt + 1) % (1 << CNT_W);
        exp_q.push_back('{tmo: tmo, fun: fun, cnt: model_cnt});
        for (int c = 1; c <= busy; c++) begin
            @(negedge CLK);
            chk("enable_busy", int'(Unit_Enable), onehot(fun));
            chk("in_ready_busy", int'(In_Ready), 0);
            In_Valid  = 1'($urandom);
            ALU_FUN   = FUN_W'($urandom);
            Unit_Done = N'($urandom) & ~N'(onehot(fun));
            if (c == d) Unit_Done = Unit_Done | N'(onehot(fun));
        end
        if (gap) begin
            @(negedge CLK);
            In_Valid  = 1'b0;
            Unit_Done = N'($urandom);
        end
    endtask

    task automatic reset_mid_busy();
        @(negedge CLK);
        In_Valid  = 1'b1;
        ALU_FUN   = 2'b10;
        Unit_Done = '0;
        @(negedge CLK);
        In_Valid = 1'b0;
        chk("enable_pre_reset", int'(Unit_Enable), 4);
        #2 RST = 1'b0;
        #1;
        chk("rst_enable", int'(Unit_Enable), 0);
        chk("rst_ready", int'(In_Ready), 1);
        chk("rst_fun", int'(Active_Fun), 0);
        chk("rst_count", int'(Op_Count), 0);
        chk("rst_valid", int'(Out_Valid), 0);
        chk("rst_tmo", int'(Timeout_Err), 0);
        model_cnt = 0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("post_rst_ready", int'(In_Ready), 1);
        chk("post_rst_count", int'(Op_Count), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef DISPATCH_WATCHDOG_EN
        watchdog = 1'b1;
`endif
        #12;
        chk("reset_ready", int'(In_Ready), 1);
        chk("reset_enable", int'(Unit_Enable), 0);
        chk("reset_count", int'(Op_Count), 0);
        chk("reset_tmo", int'(Timeout_Err), 0);
        @(negedge CLK);
        RST = 1'b1;

        // Decode all codes back-to-back with single-cycle units; count wraps at CNT_W=2.
        for (int f = 0; f < N; f++) do_op(f, 1, 1'b0);
        do_op(1, 1, 1'b1);

        // Wrong-unit done noise while CMP is active, then its own done.
        do_op(2, 3, 1'b1);

        reset_mid_busy();

        for (int i = 0; i < 40; i++)
            do_op(int'($urandom_range(0, N - 1)), int'($urandom_range(1, 6)), 1'($urandom));

        if (watchdog) begin
            do_op(3, TMO, 1'b1);
            do_op(0, TMO + 1, 1'b0);
            do_op(1, 1, 1'b1);
        end else begin
            do_op(3, 100, 1'b1);
        end

        @(negedge CLK);
        In_Valid  = 1'b0;
        Unit_Done = '0;
        repeat (4) @(negedge CLK);
        chk("queue_drained", exp_q.size(), 0);
        chk("final_count", int'(Op_Count), model_cnt);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
